execute_muldiv_unit: RTL and testbench
======================================

Name: execute_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the Execute stage, fed by the decode-to-execute pipeline register (operand values after forwarding, M-extension function code).
- Raises a stall request to the hazard unit while it computes, so the fetch, decode and execute stages hold.
- Presents a 32-bit result for one cycle, which the execute-to-memory register captures in place of the ALU result.

Parameters:
- XLEN, 32, operand/result width; even, >= 8.
- CNT_W, $clog2(XLEN), iteration counter width; derived, do not override.

Ports:
- clk  in  1  pipeline clock; all state updates on the falling edge, same as the pipeline registers.
- reset  in  1  asynchronous, active-low; low forces the idle state immediately.
- start  in  1  valid M-extension instruction present in Execute.
- kill  in  1  abort the current operation; driven by FlushE.
- funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op_a  in  XLEN  rs1 value after forwarding.
- op_b  in  XLEN  rs2 value after forwarding.
- stall_req  out  1  hold F/D/E; combinational from state and start.
- done  out  1  result valid this cycle.
- result  out  XLEN  product or quotient/remainder.

Behaviour:
- Reset (async): state=IDLE, counter=0, done=0, result=0, all internal registers 0.
- States:
  - IDLE: if start&~kill, latch funct3, operand magnitudes and result signs.
    - Special divide case -> DONE.
    - Otherwise -> CALC with counter=0.
  - CALC: one radix-2 step per cycle; counter increments; after the step with counter==XLEN-1 -> DONE.
  - DONE: done=1, result driven; unconditionally -> IDLE.
- Latency:
  - stall_req = (IDLE & start & ~kill) | CALC.
  - stall_req is 0 in DONE, so the pipeline advances and the E/M register captures result at the end of the DONE cycle.
  - Normal op: 1 IDLE cycle + XLEN CALC cycles = XLEN+1 stall cycles (33 at XLEN=32), then 1 DONE cycle.
  - Special case: 1 stall cycle, then DONE.
- Handshake:
  - start is sampled only in IDLE; start in CALC/DONE is ignored.
  - A new M instruction that enters Execute after DONE is seen in the following IDLE cycle, so back-to-back ops run with no lost instruction.
- Multiply:
  - Unsigned shift-add on magnitudes into a 2*XLEN accumulator.
  - Signedness: MUL and MULH treat both operands as signed; MULHSU treats op_a as signed and op_b as unsigned; MULHU treats both as unsigned.
  - If the result sign is negative, the 2*XLEN product is negated in DONE.
  - MUL returns the low XLEN bits; the other three return the high XLEN bits.
- Divide:
  - Restoring division on magnitudes.
  - Quotient is negative when signed and the operand signs differ.
  - Remainder takes the sign of the dividend.
- Special cases, resolved in IDLE:
  - Divisor 0: quotient = all ones, remainder = op_a (signed and unsigned).
  - Signed overflow (op_a = most negative value, op_b = -1): quotient = op_a, remainder = 0.
- kill:
  - In any state, kill forces -> IDLE next edge, done stays 0, and stall_req drops in the same cycle except where CALC remains registered.
  - Hazard unit gating is required: kill overrides stall in the hazard unit.
  - kill and start together in IDLE: no operation starts.
- Outside DONE, result holds its last value and done=0.
- Reset asserted mid-operation: immediate IDLE, no done pulse.

Decomposition:
- Shared package holds:
  - funct3 localparams (FN_MUL..FN_REMU);
  - state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2);
  - the is_div helper (funct3[2]).
- One natural sub-module, muldiv_iter_core:
  - Holds the accumulator/remainder registers and the per-step add/subtract-shift datapath.
  - The top level keeps the FSM, counter, special-case detection and sign fix-up.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD -> stall_req high 33 cycles, then done=1 with result=0xFFFFFFEB for exactly one cycle.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 0x1234 / 0 -> 0xFFFFFFFF after 1 stall cycle; REM 0x1234 / 0 -> 0x1234; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Start MUL, assert kill in CALC cycle 10 -> IDLE next edge, no done pulse; reset low mid-CALC -> stall_req=0 and state IDLE immediately.
- Back-to-back DIVU 9/3 then MUL 5x6 with start held -> done pulses give 3 then 30, separated by 33 stall cycles.

Source files
------------

// File: rtl/execute_muldiv_unit_pkg.sv
// Shared definitions for the Execute-stage RV32M multiply/divide unit.
package execute_muldiv_unit_pkg;

    // M-extension function codes (instruction funct3 field)
    localparam logic [2:0] FN_MUL    = 3'd0;
    localparam logic [2:0] FN_MULH   = 3'd1;
    localparam logic [2:0] FN_MULHSU = 3'd2;
    localparam logic [2:0] FN_MULHU  = 3'd3;
    localparam logic [2:0] FN_DIV    = 3'd4;
    localparam logic [2:0] FN_DIVU   = 3'd5;
    localparam logic [2:0] FN_REM    = 3'd6;
    localparam logic [2:0] FN_REMU   = 3'd7;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // All divide/remainder codes have funct3[2] set
    function automatic logic is_div(input logic [2:0] fn);
        return fn[2];
    endfunction

endpackage

// File: rtl/execute_muldiv_unit_iter_core.sv
// Iterative radix-2 datapath: shift-add multiply or restoring divide on
// unsigned magnitudes. Working pair {hi, lo} is the 2*XLEN product for a
// multiply, and {remainder, quotient} for a divide.
module muldiv_iter_core
    import execute_muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic            div_mode,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    output logic [XLEN-1:0] hi_step,
    output logic [XLEN-1:0] lo_step
);

    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] m_q, m_d;
    logic            div_q, div_d;

    logic [XLEN:0] add_sum;
    logic [XLEN:0] rem_shift;
    logic [XLEN:0] rem_diff;

    // One iteration: conditional add + right shift, or trial subtract + left shift
    always_comb begin
        add_sum   = {1'b0, hi_q} + ({1'b0, m_q} & {(XLEN+1){lo_q[0]}});
        rem_shift = {hi_q, lo_q[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, m_q};
        if (div_q) begin
            if (rem_diff[XLEN]) begin
                // trial subtract went negative: restore, quotient bit 0
                hi_step = rem_shift[XLEN-1:0];
                lo_step = {lo_q[XLEN-2:0], 1'b0};
            end else begin
                hi_step = rem_diff[XLEN-1:0];
                lo_step = {lo_q[XLEN-2:0], 1'b1};
            end
        end else begin
            hi_step = add_sum[XLEN:1];
            lo_step = {add_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // Next-state select: load fresh operands, advance one step, or hold
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        hi_d  = hi_q;
        lo_d  = lo_q;
        m_d   = m_q;
        div_d = div_q;
        if (load) begin
            hi_d  = '0;
            lo_d  = div_mode ? a_mag : b_mag;
            m_d   = div_mode ? b_mag : a_mag;
            div_d = div_mode;
        end else if (step) begin
            hi_d = hi_step;
            lo_d = lo_step;
        end
    end

    // Datapath registers, updated on the falling edge like the pipeline registers
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            div_q <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            m_q   <= m_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/execute_muldiv_unit.sv
// Execute-stage RV32M multiply/divide unit. Holds the pipeline via stall_req
// while iterating, then presents the result with a one-cycle done pulse.
module execute_muldiv_unit
    import execute_muldiv_unit_pkg::*;
#(
    parameter int  XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       fn_q, fn_d;
    logic             neg_q, neg_d;
    logic             done_q, done_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_by_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;
    logic            core_load, core_step;
    logic [XLEN-1:0] core_hi, core_lo;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix, calc_res;

    // Operand signedness, magnitudes and divide special cases for the incoming op
    always_comb begin
        a_signed    = (funct3 != FN_MULHU) && (funct3 != FN_DIVU) && (funct3 != FN_REMU);
        b_signed    = (funct3 == FN_MUL) || (funct3 == FN_MULH) ||
                      (funct3 == FN_DIV) || (funct3 == FN_REM);
        a_neg       = a_signed & op_a[XLEN-1];
        b_neg       = b_signed & op_b[XLEN-1];
        a_mag       = a_neg ? (~op_a + XLEN'(1)) : op_a;
        b_mag       = b_neg ? (~op_b + XLEN'(1)) : op_b;
        div_by_zero = is_div(funct3) && (op_b == '0);
        div_ovf     = ((funct3 == FN_DIV) || (funct3 == FN_REM)) &&
                      (op_a == INT_MIN) && (op_b == '1);
        special     = div_by_zero || div_ovf;
        // funct3[1] selects remainder among the divide codes
        if (div_by_zero) begin
            special_res = funct3[1] ? op_a : '1;
        end else begin
            special_res = funct3[1] ? '0 : op_a;
        end
    end

    // Sign fix-up and word select applied to the value the final step produces
    always_comb begin
        prod     = {core_hi, core_lo};
        prod_fix = neg_q ? (~prod + (2*XLEN)'(1)) : prod;
        quo_fix  = neg_q ? (~core_lo + XLEN'(1)) : core_lo;
        rem_fix  = neg_q ? (~core_hi + XLEN'(1)) : core_hi;
        if (is_div(fn_q)) begin
            calc_res = fn_q[1] ? rem_fix : quo_fix;
        end else begin
            calc_res = (fn_q == FN_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
    end

    // FSM next-state, counter and registered output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fn_d      = fn_q;
        neg_d     = neg_q;
        done_d    = 1'b0;
        result_d  = result_q;
        core_load = 1'b0;
        core_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !kill) begin
                    fn_d  = funct3;
                    // remainder follows the dividend; everything else the operand-sign xor
                    neg_d = (is_div(funct3) && funct3[1]) ? a_neg : (a_neg ^ b_neg);
                    cnt_d = '0;
                    if (special) begin
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                        result_d = special_res;
                    end else begin
                        state_d   = ST_CALC;
                        core_load = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                core_step = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    result_d = calc_res;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // a flush abandons whatever is in flight and publishes nothing
        if (kill) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    // Control state register, falling-edge clocked with the pipeline
    always_ff @(negedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            fn_q     <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fn_q     <= fn_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    muldiv_iter_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (core_load),
        .step     (core_step),
        .div_mode (is_div(funct3)),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .hi_step  (core_hi),
        .lo_step  (core_lo)
    );

    assign stall_req = ((state_q == ST_IDLE) && start && !kill) || (state_q == ST_CALC);
    assign done      = done_q;
    assign result    = result_q;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Self-checking bench for execute_muldiv_unit: directed cases plus random
// operations compared against a plain-arithmetic RV32M reference.
module tb_execute_muldiv_unit;
    import execute_muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        stall_req;
    logic        done;
    logic [31:0] result;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_result = '0;

    execute_muldiv_unit #(
        .XLEN (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .kill      (kill),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .stall_req (stall_req),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: RV32M semantics from 64-bit integer arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            FN_MUL:    begin p = sa * sb;            return p[31:0];  end
            FN_MULH:   begin p = sa * sb;            return p[63:32]; end
            FN_MULHSU: begin p = sa * longint'(ub);  return p[63:32]; end
            FN_MULHU:  begin p = ua * ub;            return p[63:32]; end
            FN_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb;
                return p[31:0];
            end
            FN_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub;
                return p[31:0];
            end
            FN_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub;
                return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_stalls(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == FN_DIV || f == FN_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Count stall cycles until done, then check the done cycle itself
    task automatic wait_done(input string tag, input logic [31:0] exp, input int exp_stalls);
        int   stalls;
        logic seen;
        stalls = 0;
        seen   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (stall_req) stalls++;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_result"}, result, exp);
            check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
            check({tag, "_stall_in_done"}, 32'(stall_req), 32'd0);
            last_result = exp;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b);
        @(negedge clk);
        #1;
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        wait_done(tag, ref_model(f, a, b), ref_stalls(f, a, b));
        @(negedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    task automatic expect_no_done(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            if (done) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;

        reset  = 1'b0;
        start  = 1'b0;
        kill   = 1'b0;
        funct3 = '0;
        op_a   = '0;
        op_b   = '0;

        // reset state
        repeat (3) @(posedge clk);
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        #1 reset = 1'b1;
        @(posedge clk);
        check("idle_stall", 32'(stall_req), 32'd0);

        // directed cases
        run_op("mul_7_m3",      FN_MUL,    32'd7,          32'hFFFF_FFFD);
        run_op("mulh_min_min",  FN_MULH,   32'h8000_0000, 32'h8000_0000);
        run_op("mulhu_min_min", FN_MULHU,  32'h8000_0000, 32'h8000_0000);
        run_op("mulhsu_m1_2",   FN_MULHSU, 32'hFFFF_FFFF, 32'd2);
        run_op("div_m7_2",      FN_DIV,    32'hFFFF_FFF9, 32'd2);
        run_op("rem_m7_2",      FN_REM,    32'hFFFF_FFF9, 32'd2);
        run_op("divu_100_7",    FN_DIVU,   32'd100,        32'd7);
        run_op("remu_100_7",    FN_REMU,   32'd100,        32'd7);
        run_op("divu_by0",      FN_DIVU,   32'h1234,       32'd0);
        run_op("rem_by0",       FN_REM,    32'h1234,       32'd0);
        run_op("div_ovf",       FN_DIV,    32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf",       FN_REM,    32'h8000_0000, 32'hFFFF_FFFF);

        // kill during CALC cycle 10
        @(negedge clk);
        #1;
        start  = 1'b1;
        funct3 = FN_MUL;
        op_a   = 32'd123;
        op_b   = 32'd456;
        repeat (11) @(negedge clk);
        #1;
        start = 1'b0;
        kill  = 1'b1;
        @(posedge clk);
        check("kill_stall_in_calc", 32'(stall_req), 32'd1);
        @(negedge clk);
        #1 kill = 1'b0;
        @(posedge clk);
        check("kill_stall_after", 32'(stall_req), 32'd0);
        expect_no_done("kill_no_done", 40);
        check("kill_result_held", result, last_result);

        // kill and start together in IDLE start nothing
        @(negedge clk);
        #1;
        start  = 1'b1;
        kill   = 1'b1;
        funct3 = FN_DIVU;
        op_a   = 32'd5;
        op_b   = 32'd0;
        @(posedge clk);
        check("kill_start_stall", 32'(stall_req), 32'd0);
        @(negedge clk);
        #1;
        start = 1'b0;
        kill  = 1'b0;
        expect_no_done("kill_start_no_done", 5);

        // reset mid-CALC
        @(negedge clk);
        #1;
        start  = 1'b1;
        funct3 = FN_DIVU;
        op_a   = 32'd1000;
        op_b   = 32'd3;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        #1;
        check("rst_mid_stall", 32'(stall_req), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_result", result, 32'd0);
        last_result = '0;
        @(negedge clk);
        #1 reset = 1'b1;
        expect_no_done("rst_mid_no_done", 40);

        // back-to-back with start held
        @(negedge clk);
        #1;
        start  = 1'b1;
        funct3 = FN_DIVU;
        op_a   = 32'd9;
        op_b   = 32'd3;
        wait_done("b2b_divu", 32'd3, 33);
        @(negedge clk);
        #1;
        funct3 = FN_MUL;
        op_a   = 32'd5;
        op_b   = 32'd6;
        wait_done("b2b_mul", 32'd30, 33);
        @(negedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        check("b2b_done_one_cycle", 32'(done), 32'd0);

        // random operations, biased toward divide corner cases
        for (int i = 0; i < 40; i++) begin
            f   = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 7);
            a   = $urandom;
            b   = $urandom;
            case (sel)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 255)); b = 32'($urandom_range(1, 15)); end
                3: b = 32'($urandom_range(1, 3)) | (b & 32'h8000_0000);
                default: ;
            endcase
            run_op($sformatf("rnd%0d_f%0d", i, f), f, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
